// File: rtl/multimode_wave_gen.sv
// Waveform sequencer for the DAC path: triangle, saw up, saw down or square
// between programmable lo/hi limits, advancing one step per divider tick.
module multimode_wave_gen #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned DIV_WIDTH = 30
) (
  input  logic                 qzt_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic [WIDTH-1:0]     step,
  input  logic [WIDTH-1:0]     lo,
  input  logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     sample,
  output logic                 sample_stb,
  output logic                 dir_down,
  output logic                 wrap
);

  localparam logic [1:0] MODE_TRI      = 2'd0;
  localparam logic [1:0] MODE_SAW_UP   = 2'd1;
  localparam logic [1:0] MODE_SAW_DOWN = 2'd2;
  localparam logic [1:0] MODE_SQUARE   = 2'd3;

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_last;
  logic [1:0]           mode_q;
  logic                 tick;

  // One extra bit on all arithmetic so step additions cannot overflow.
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   lo_ext;
  logic [WIDTH:0]   hi_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   lo_plus;
  logic [WIDTH:0]   dn_diff;

  logic [WIDTH-1:0] nxt_sample;
  logic             nxt_dir;
  logic             nxt_wrap;

  assign s_ext    = {1'b0, sample};
  assign lo_ext   = {1'b0, lo};
  assign hi_ext   = {1'b0, hi};
  assign step_ext = (step == '0) ? (WIDTH+1)'(1) : {1'b0, step};
  assign up_sum   = s_ext + step_ext;
  assign lo_plus  = lo_ext + step_ext;
  assign dn_diff  = s_ext - step_ext;

  // Period 0 behaves as period 1, so the terminal count is 0 in both cases.
  assign div_last = (period == '0) ? '0 : period - DIV_WIDTH'(1);
  assign tick     = enable && (div_q == div_last);

  // Next sample, direction and wrap flag to apply on a tick.
  always_comb begin
    nxt_sample = sample;
    nxt_dir    = 1'b0;
    nxt_wrap   = 1'b0;
    if (lo >= hi) begin
      nxt_sample = lo;
    end else if ((sample < lo) || (sample > hi)) begin
      // Re-entry into the window, not counted as a step.
      nxt_sample = lo;
    end else begin
      case (mode_q)
        MODE_TRI: begin
          if (!dir_down) begin
            if (up_sum >= hi_ext) begin
              nxt_sample = hi;
              nxt_dir    = 1'b1;
              nxt_wrap   = 1'b1;
            end else begin
              nxt_sample = up_sum[WIDTH-1:0];
            end
          end else begin
            if (s_ext <= lo_plus) begin
              nxt_sample = lo;
              nxt_wrap   = 1'b1;
            end else begin
              nxt_sample = dn_diff[WIDTH-1:0];
              nxt_dir    = 1'b1;
            end
          end
        end
        MODE_SAW_UP: begin
          if (up_sum > hi_ext) begin
            nxt_sample = lo;
            nxt_wrap   = 1'b1;
          end else begin
            nxt_sample = up_sum[WIDTH-1:0];
          end
        end
        MODE_SAW_DOWN: begin
          if (s_ext < lo_plus) begin
            nxt_sample = hi;
            nxt_wrap   = 1'b1;
          end else begin
            nxt_sample = dn_diff[WIDTH-1:0];
          end
        end
        MODE_SQUARE: begin
          nxt_sample = (sample == lo) ? hi : lo;
          nxt_wrap   = 1'b1;
        end
        default: begin
          nxt_sample = lo;
        end
      endcase
    end
  end

  // Divider, mode tracking and registered outputs; mode change beats a tick.
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      div_q      <= '0;
      mode_q     <= MODE_TRI;
      sample     <= '0;
      dir_down   <= 1'b0;
      sample_stb <= 1'b0;
      wrap       <= 1'b0;
    end else if (mode != mode_q) begin
      mode_q     <= mode;
      div_q      <= '0;
      sample     <= lo;
      dir_down   <= 1'b0;
      sample_stb <= 1'b1;
      wrap       <= 1'b0;
    end else if (!enable) begin
      div_q      <= '0;
      sample_stb <= 1'b0;
      wrap       <= 1'b0;
    end else if (tick) begin
      div_q      <= '0;
      sample     <= nxt_sample;
      dir_down   <= nxt_dir;
      sample_stb <= 1'b1;
      wrap       <= nxt_wrap;
    end else begin
      div_q      <= div_q + DIV_WIDTH'(1);
      sample_stb <= 1'b0;
      wrap       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multimode_wave_gen.sv
// Directed bench for multimode_wave_gen; each task checks {sample, stb, wrap, dir}.
module tb_multimode_wave_gen;

  logic        qzt_clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [29:0] period;
  logic [11:0] step;
  logic [11:0] lo;
  logic [11:0] hi;
  logic [11:0] sample;
  logic        sample_stb;
  logic        dir_down;
  logic        wrap;

  int errors;
  int checks;
  logic [14:0] got;

  multimode_wave_gen #(
    .WIDTH     (12),
    .DIV_WIDTH (30)
  ) dut (
    .qzt_clk    (qzt_clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .period     (period),
    .step       (step),
    .lo         (lo),
    .hi         (hi),
    .sample     (sample),
    .sample_stb (sample_stb),
    .dir_down   (dir_down),
    .wrap       (wrap)
  );

  initial qzt_clk = 1'b0;
  always #5 qzt_clk = ~qzt_clk;

  // Advance one clock and settle past the edge.
  task automatic cyc();
    @(posedge qzt_clk);
    #1;
  endtask

  task automatic pulse_reset();
    enable = 1'b0;
    reset  = 1'b1;
    cyc();
    cyc();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    mode   = 2'd2;
    period = 30'd1;
    step   = 12'd5;
    lo     = 12'd7;
    hi     = 12'd90;
    for (int i = 0; i < 3; i++) begin
      cyc();
      got = {sample, sample_stb, wrap, dir_down};
      checks++;
      if (got !== 15'd0) begin
        errors++;
        $display("FAIL reset i=%0d got s=%0d swd=%b exp s=0 swd=000", i, got[14:3], got[2:0]);
      end
    end
    mode   = 2'd0;
    enable = 1'b0;
    cyc();
  endtask

  task automatic test_tri_full();
    logic [14:0] exp;
    int shown;
    shown  = 0;
    mode   = 2'd0;
    lo     = 12'd0;
    hi     = 12'd4095;
    step   = 12'd1;
    period = 30'd1;
    pulse_reset();
    enable = 1'b1;
    for (int k = 1; k <= 8190; k++) begin
      cyc();
      exp[14:3] = (k <= 4095) ? 12'(k) : 12'(8190 - k);
      exp[2]    = 1'b1;
      exp[1]    = (k == 4095) || (k == 8190);
      exp[0]    = (k >= 4095) && (k < 8190);
      got = {sample, sample_stb, wrap, dir_down};
      checks++;
      if (got !== exp) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL tri_full k=%0d got s=%0d swd=%b exp s=%0d swd=%b",
                   k, got[14:3], got[2:0], exp[14:3], exp[2:0]);
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_tri_step();
    logic [11:0] ts [10];
    logic [14:0] exp;
    logic [11:0] prev_s;
    logic        prev_d;
    ts = '{12'd1000, 12'd2000, 12'd3000, 12'd4000, 12'd4095,
           12'd3095, 12'd2095, 12'd1095, 12'd95, 12'd0};
    mode   = 2'd0;
    lo     = 12'd0;
    hi     = 12'd4095;
    step   = 12'd1000;
    period = 30'd4;
    pulse_reset();
    enable = 1'b1;
    prev_s = 12'd0;
    prev_d = 1'b0;
    for (int t = 0; t < 10; t++) begin
      for (int c = 0; c < 4; c++) begin
        cyc();
        if (c < 3) begin
          exp = {prev_s, 2'b00, prev_d};
        end else begin
          exp = {ts[t], 1'b1, (t == 4) || (t == 9), (t >= 4) && (t < 9)};
          prev_s = ts[t];
          prev_d = (t >= 4) && (t < 9);
        end
        got = {sample, sample_stb, wrap, dir_down};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL tri_step t=%0d c=%0d got s=%0d swd=%b exp s=%0d swd=%b",
                   t, c, got[14:3], got[2:0], exp[14:3], exp[2:0]);
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_reentry_saw();
    logic [14:0] tab [13];
    tab = '{{12'd100, 3'b100}, {12'd250, 3'b100}, {12'd400, 3'b111},
            {12'd100, 3'b100}, {12'd250, 3'b100}, {12'd400, 3'b100},
            {12'd100, 3'b110}, {12'd250, 3'b100},
            {12'd100, 3'b100}, {12'd400, 3'b110}, {12'd250, 3'b100},
            {12'd100, 3'b100}, {12'd400, 3'b110}};
    mode   = 2'd0;
    lo     = 12'd100;
    hi     = 12'd400;
    step   = 12'd150;
    period = 30'd1;
    pulse_reset();
    enable = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) mode = 2'd1;
      if (i == 8) mode = 2'd2;
      cyc();
      got = {sample, sample_stb, wrap, dir_down};
      checks++;
      if (got !== tab[i]) begin
        errors++;
        $display("FAIL reentry_saw i=%0d got s=%0d swd=%b exp s=%0d swd=%b",
                 i, got[14:3], got[2:0], tab[i][14:3], tab[i][2:0]);
      end
    end
  endtask

  task automatic test_square();
    logic [14:0] tab [16];
    tab = '{{12'd10, 3'b100}, {12'd10, 3'b000}, {12'd10, 3'b000}, {12'd20, 3'b110},
            {12'd20, 3'b000}, {12'd20, 3'b000}, {12'd10, 3'b110}, {12'd10, 3'b000},
            {12'd10, 3'b000}, {12'd20, 3'b110}, {12'd20, 3'b000}, {12'd20, 3'b000},
            {12'd50, 3'b100}, {12'd50, 3'b000}, {12'd50, 3'b000}, {12'd50, 3'b100}};
    mode   = 2'd3;
    lo     = 12'd10;
    hi     = 12'd20;
    period = 30'd3;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) begin
        lo = 12'd50;
        hi = 12'd50;
      end
      cyc();
      got = {sample, sample_stb, wrap, dir_down};
      checks++;
      if (got !== tab[i]) begin
        errors++;
        $display("FAIL square i=%0d got s=%0d swd=%b exp s=%0d swd=%b",
                 i, got[14:3], got[2:0], tab[i][14:3], tab[i][2:0]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_mode_change();
    logic [14:0] tab [15];
    tab = '{{12'd0, 3'b000}, {12'd1000, 3'b100}, {12'd1000, 3'b000},
            {12'd2000, 3'b100}, {12'd2000, 3'b000}, {12'd3000, 3'b111},
            {12'd3000, 3'b001}, {12'd2000, 3'b101}, {12'd2000, 3'b001},
            {12'd0, 3'b100}, {12'd0, 3'b000}, {12'd1000, 3'b100},
            {12'd0, 3'b100}, {12'd0, 3'b000}, {12'd3000, 3'b110}};
    mode   = 2'd0;
    lo     = 12'd0;
    hi     = 12'd3000;
    step   = 12'd1000;
    period = 30'd2;
    pulse_reset();
    enable = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 9)  mode = 2'd1;
      if (i == 12) mode = 2'd2;
      cyc();
      got = {sample, sample_stb, wrap, dir_down};
      checks++;
      if (got !== tab[i]) begin
        errors++;
        $display("FAIL mode_change i=%0d got s=%0d swd=%b exp s=%0d swd=%b",
                 i, got[14:3], got[2:0], tab[i][14:3], tab[i][2:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] tab [5];
    tab = '{{12'd0, 3'b100}, {12'd1000, 3'b100}, {12'd2000, 3'b100},
            {12'd3000, 3'b111}, {12'd2000, 3'b101}};
    mode   = 2'd0;
    lo     = 12'd0;
    hi     = 12'd3000;
    step   = 12'd1000;
    period = 30'd1;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      got = {sample, sample_stb, wrap, dir_down};
      checks++;
      if (got !== tab[i]) begin
        errors++;
        $display("FAIL reset_mid_run i=%0d got s=%0d swd=%b exp s=%0d swd=%b",
                 i, got[14:3], got[2:0], tab[i][14:3], tab[i][2:0]);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        reset  = 1'b0;
        enable = 1'b0;
      end
      cyc();
      got = {sample, sample_stb, wrap, dir_down};
      checks++;
      if (got !== 15'd0) begin
        errors++;
        $display("FAIL reset_mid i=%0d got s=%0d swd=%b exp s=0 swd=000",
                 i, got[14:3], got[2:0]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    logic [14:0] exp;
    period = 30'd2;
    enable = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (i == 3)  enable = 1'b0;
      if (i == 23) enable = 1'b1;
      if (i == 25) begin
        period = 30'd0;
        step   = 12'd0;
      end
      cyc();
      if (i == 0)       exp = {12'd0, 3'b000};
      else if (i == 1)  exp = {12'd1000, 3'b100};
      else if (i < 24)  exp = {12'd1000, 3'b000};
      else if (i == 24) exp = {12'd2000, 3'b100};
      else if (i == 25) exp = {12'd2001, 3'b100};
      else              exp = {12'd2002, 3'b100};
      got = {sample, sample_stb, wrap, dir_down};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL enable_freeze i=%0d got s=%0d swd=%b exp s=%0d swd=%b",
                 i, got[14:3], got[2:0], exp[14:3], exp[2:0]);
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    enable = 1'b0;
    mode   = 2'd0;
    period = 30'd1;
    step   = 12'd1;
    lo     = 12'd0;
    hi     = 12'd0;
    test_reset();
    test_tri_full();
    test_tri_step();
    test_reentry_saw();
    test_square();
    test_mode_change();
    test_reset_mid();
    test_enable_freeze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
